// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Round-robin arbiter that shares one single-ported memory between three
// requesters: instruction fetch (port 0), data load/store (port 1) and the
// debug/loader port (port 2). A granted access is held on the memory bus
// for WAIT_CYCLES+1 cycles. Read data is captured on the last of those
// cycles. Completion is signalled with a one-cycle acknowledge.
//
// Parameters
//   AW           address width
//   DW           data width
//   WAIT_CYCLES  memory wait states per access (0 is legal)
//
// Ports
//   clk                  clock, all logic on the rising edge
//   reset                asynchronous active-low reset (0 = reset)
//   req[2:0]             per-port request, held high until ack
//   we[2:0]              per-port write enable, valid while req is high
//   addr0..addr2         per-port address
//   wdata0..wdata2       per-port write data
//   ack[2:0]             one-hot, one-cycle completion pulse
//   gnt[2:0]             one-hot grant, high from the first ACCESS cycle through DONE
//   rdata                read data of the last completed read, held afterwards
//   mem_cs/mem_we        memory select / write strobe
//   mem_addr/mem_wdata   memory address / write data
//   mem_rdata            memory read data, valid on the last ACCESS cycle

module mem_arbiter #(
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    output logic [2:0]    ack,
    output logic [2:0]    gnt,
    output logic [DW-1:0] rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // The counter must hold WAIT_CYCLES. With zero wait states, keep a 1-bit counter.
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    last_gnt, last_gnt_n;
    logic [1:0]    win, win_n;
    logic [1:0]    pick;
    logic [2:0]    ack_n, gnt_n;
    logic [DW-1:0] rdata_n;
    logic          mem_cs_n, mem_we_n;
    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] mem_wdata_n;

    // Search starts at the port after the last one served and wraps 0->1->2->0.
    // The result is only meaningful when at least one request is present.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] p;
        p = 2'd0;
        case (last)
            2'd0: begin
                if (r[1])      p = 2'd1;
                else if (r[2]) p = 2'd2;
                else           p = 2'd0;
            end
            2'd1: begin
                if (r[2])      p = 2'd2;
                else if (r[0]) p = 2'd0;
                else           p = 2'd1;
            end
            default: begin
                if (r[0])      p = 2'd0;
                else if (r[1]) p = 2'd1;
                else           p = 2'd2;
            end
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last_gnt  <= 2'd2;
            win       <= 2'd0;
            ack       <= '0;
            gnt       <= '0;
            rdata     <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last_gnt  <= last_gnt_n;
            win       <= win_n;
            ack       <= ack_n;
            gnt       <= gnt_n;
            rdata     <= rdata_n;
            mem_cs    <= mem_cs_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

    // Every output is a register. This block only computes the values
    // loaded on the next edge. Port inputs are looked at only in IDLE.
    // After the grant, the latched copies drive the memory bus, so a
    // requester that drops req mid-access cannot disturb it.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        last_gnt_n  = last_gnt;
        win_n       = win;
        ack_n       = ack;
        gnt_n       = gnt;
        rdata_n     = rdata;
        mem_cs_n    = mem_cs;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        pick        = rr_pick(req, last_gnt);

        case (state)
            IDLE: begin
                if (|req) begin
                    win_n    = pick;
                    gnt_n    = 3'b001 << pick;
                    mem_cs_n = 1'b1;
                    mem_we_n = we[pick];
                    cnt_n    = CW'(WAIT_CYCLES);
                    state_n  = ACCESS;
                    case (pick)
                        2'd0: begin
                            mem_addr_n  = addr0;
                            mem_wdata_n = wdata0;
                        end
                        2'd1: begin
                            mem_addr_n  = addr1;
                            mem_wdata_n = wdata1;
                        end
                        default: begin
                            mem_addr_n  = addr2;
                            mem_wdata_n = wdata2;
                        end
                    endcase
                end else begin
                    mem_cs_n = 1'b0;
                end
            end

            ACCESS: begin
                if (cnt == '0) begin
                    if (!mem_we) begin
                        rdata_n = mem_rdata;
                    end
                    mem_cs_n   = 1'b0;
                    mem_we_n   = 1'b0;
                    ack_n      = 3'b001 << win;
                    last_gnt_n = win;
                    state_n    = DONE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end

            DONE: begin
                ack_n   = '0;
                gnt_n   = '0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. Requester tasks issue transactions
// and push the expected outcome into one scoreboard queue per port. A
// free-running monitor compares each grant and acknowledge from the DUT
// against the queues and a round-robin reference. A second instance with
// zero wait states covers the shortest access.

module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int W  = 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    req, we;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [DW-1:0] wdata0, wdata1, wdata2;
    logic [2:0]    ack, gnt;
    logic [DW-1:0] rdata;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [2:0]    req_z, we_z;
    logic [AW-1:0] addr0_z, addr1_z, addr2_z;
    logic [DW-1:0] wdata0_z, wdata1_z, wdata2_z;
    logic [2:0]    ack_z, gnt_z;
    logic [DW-1:0] rdata_z;
    logic          mem_cs_z, mem_we_z;
    logic [AW-1:0] mem_addr_z;
    logic [DW-1:0] mem_wdata_z, mem_rdata_z;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .ack(ack), .gnt(gnt), .rdata(rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .req(req_z), .we(we_z),
        .addr0(addr0_z), .addr1(addr1_z), .addr2(addr2_z),
        .wdata0(wdata0_z), .wdata1(wdata1_z), .wdata2(wdata2_z),
        .ack(ack_z), .gnt(gnt_z), .rdata(rdata_z),
        .mem_cs(mem_cs_z), .mem_we(mem_we_z), .mem_addr(mem_addr_z),
        .mem_wdata(mem_wdata_z), .mem_rdata(mem_rdata_z)
    );

    // Memory contents before any write, shared by the environment memory
    // and the reference model.
    function automatic logic [DW-1:0] init_pattern(input logic [AW-1:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    // Environment memory. Read data is garbage whenever the select is low.
    logic [DW-1:0] env_mem [256];
    bit            env_written [256];
    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            env_mem[mem_addr]     <= mem_wdata;
            env_written[mem_addr] <= 1'b1;
        end
    end
    assign mem_rdata   = mem_cs ? (env_written[mem_addr] ? env_mem[mem_addr]
                                                         : init_pattern(mem_addr))
                                : 16'hDEAD;
    assign mem_rdata_z = mem_cs_z ? 16'hA5C3 : 16'h0000;

    // Reference model: a plain shadow memory updated when a transaction is issued.
    logic [DW-1:0] ref_mem [256];
    bit            ref_written [256];
    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_written[a] ? ref_mem[a] : init_pattern(a);
    endfunction

    // Scoreboard queues, one per requester.
    txn_t q0[$], q1[$], q2[$];

    function automatic int sb_size(input int p);
        case (p)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void sb_push(input int p, input txn_t t);
        case (p)
            0:       q0.push_back(t);
            1:       q1.push_back(t);
            default: q2.push_back(t);
        endcase
    endfunction

    function automatic txn_t sb_front(input int p);
        case (p)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void sb_pop(input int p);
        case (p)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    // Round-robin rule: the first requesting port after the last served one.
    function automatic int rr_expect(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (last + k) % 3;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    // Issue one transaction on port p and wait for its acknowledge. req is
    // left high so a following call re-raises without an idle gap.
    task automatic apply_stimulus(input int p, input logic w, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d);
        txn_t t;
        int   k;
        @(posedge clk);
        #1;
        t.we   = w;
        t.addr = a;
        t.data = w ? d : ref_read(a);
        if (w) begin
            ref_mem[a]     = d;
            ref_written[a] = 1'b1;
        end
        sb_push(p, t);
        case (p)
            0: begin we[0] = w; addr0 = a; wdata0 = d; end
            1: begin we[1] = w; addr1 = a; wdata1 = d; end
            default: begin we[2] = w; addr2 = a; wdata2 = d; end
        endcase
        req[p] = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ack[p]) break;
        end
        if (k == 200) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL ack_timeout port %0d: got no ack expected ack within 200 cycles", p);
        end
    endtask

    task automatic release_port(input int p);
        @(posedge clk);
        #1;
        req[p] = 1'b0;
    endtask

    task automatic port_random(input int p, input int n);
        logic [1:0] pp;
        bit         held;
        pp   = 2'(p);
        held = 1'b0;
        for (int i = 0; i < n; i++) begin
            apply_stimulus(p, 1'($urandom_range(0, 1)),
                           {pp, 6'($urandom_range(0, 7))}, 16'($urandom));
            held = 1'b1;
            if ($urandom_range(0, 2) != 0) begin
                release_port(p);
                held = 1'b0;
                repeat ($urandom_range(0, 4)) @(posedge clk);
            end
        end
        if (held) release_port(p);
    endtask

    // Monitor: checks each grant against the round-robin rule and the
    // scoreboard head. Checks the bus is held for W+1 cycles and that the
    // acknowledge arrives W+1 cycles after the grant with the right data.
    logic          mon_en = 1'b0;
    logic [2:0]    prev_req = 3'b000;
    logic [2:0]    prev_gnt = 3'b000;
    logic [DW-1:0] exp_rdata = '0;
    int            last_winner = 2;
    int            cur_port = 0;
    int            cyc = 0;
    bit            active = 1'b0;
    txn_t          t_cur;
    int            order_q[$];
    int            ackcyc_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (gnt != 3'b000 && prev_gnt == 3'b000) begin
                    int exp_p;
                    exp_p = rr_expect(prev_req, last_winner);
                    if (exp_p < 0) begin
                        check_output("grant_without_req", 32'(gnt), 32'd0);
                    end else if (sb_size(exp_p) == 0) begin
                        check_output("grant_sb_empty", 32'(sb_size(exp_p)), 32'd1);
                    end else begin
                        t_cur = sb_front(exp_p);
                        check_output("grant_port", 32'(gnt), 32'd1 << exp_p);
                        check_output("grant_cs", 32'(mem_cs), 32'd1);
                        check_output("grant_we", 32'(mem_we), 32'(t_cur.we));
                        check_output("grant_addr", 32'(mem_addr), 32'(t_cur.addr));
                        if (t_cur.we) check_output("grant_wdata", 32'(mem_wdata), 32'(t_cur.data));
                        active   = 1'b1;
                        cyc      = 0;
                        cur_port = exp_p;
                        order_q.push_back(exp_p);
                    end
                end else if (active) begin
                    cyc++;
                end

                if (active && cyc >= 1 && cyc <= W) begin
                    check_output("hold_cs", 32'(mem_cs), 32'd1);
                    check_output("hold_we", 32'(mem_we), 32'(t_cur.we));
                    check_output("hold_addr", 32'(mem_addr), 32'(t_cur.addr));
                    check_output("hold_no_ack", 32'(ack), 32'd0);
                end

                if (ack != 3'b000) begin
                    if (!active) begin
                        check_output("unexpected_ack", 32'(ack), 32'd0);
                    end else begin
                        check_output("ack_latency", 32'(cyc), 32'(W + 1));
                        check_output("ack_port", 32'(ack), 32'd1 << cur_port);
                        check_output("ack_gnt", 32'(gnt), 32'd1 << cur_port);
                        check_output("ack_cs_low", 32'(mem_cs), 32'd0);
                        if (!t_cur.we) exp_rdata = t_cur.data;
                        check_output(t_cur.we ? "rdata_held_on_write" : "rdata_read",
                                     32'(rdata), 32'(exp_rdata));
                        sb_pop(cur_port);
                        last_winner = cur_port;
                        active      = 1'b0;
                        ackcyc_q.push_back(cycle);
                    end
                end
            end
            prev_req = req;
            prev_gnt = gnt;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        reset  = 1'b1;
        req    = '0;  we     = '0;
        addr0  = '0;  addr1  = '0;  addr2  = '0;
        wdata0 = '0;  wdata1 = '0;  wdata2 = '0;
        req_z  = '0;  we_z   = '0;
        addr0_z = '0; addr1_z = '0; addr2_z = '0;
        wdata0_z = '0; wdata1_z = '0; wdata2_z = '0;
        #2 reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // Reset with all ports requesting, then contention after release:
        // each port re-raises immediately, giving 0,1,2,0,1,2 every 5 cycles.
        fork
            begin
                apply_stimulus(0, 1'b1, 8'h05, 16'h1111);
                apply_stimulus(0, 1'b0, 8'h05, 16'h0000);
                release_port(0);
            end
            begin
                apply_stimulus(1, 1'b0, 8'h41, 16'h0000);
                apply_stimulus(1, 1'b1, 8'h42, 16'h2222);
                release_port(1);
            end
            begin
                apply_stimulus(2, 1'b1, 8'h83, 16'h3333);
                apply_stimulus(2, 1'b0, 8'h84, 16'h0000);
                release_port(2);
            end
            begin
                @(posedge clk);
                #2;
                check_output("rst_req_seen", 32'(req), 32'd7);
                check_output("rst_ack", 32'(ack), 32'd0);
                check_output("rst_gnt", 32'(gnt), 32'd0);
                check_output("rst_cs", 32'(mem_cs), 32'd0);
                check_output("rst_we", 32'(mem_we), 32'd0);
                check_output("rst_addr", 32'(mem_addr), 32'd0);
                check_output("rst_wdata", 32'(mem_wdata), 32'd0);
                check_output("rst_rdata", 32'(rdata), 32'd0);
                reset = 1'b1;
            end
        join

        check_output("fair_count", 32'(order_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < order_q.size(); i++)
            check_output("fair_order", 32'(order_q[i]), 32'(i % 3));
        for (int i = 1; i < ackcyc_q.size(); i++)
            check_output("fair_ack_spacing", 32'(ackcyc_q[i] - ackcyc_q[i-1]), 32'(W + 3));
        order_q.delete();
        ackcyc_q.delete();

        // Single read returning 16'hBEEF, then a write that must leave rdata alone.
        apply_stimulus(1, 1'b0, 8'h10, 16'h0000);
        release_port(1);
        repeat (3) @(negedge clk);
        check_output("rdata_held_idle", 32'(rdata), 32'h0000BEEF);
        apply_stimulus(2, 1'b1, 8'h20, 16'h1234);
        release_port(2);
        repeat (2) @(negedge clk);
        check_output("rdata_after_write", 32'(rdata), 32'h0000BEEF);

        // Randomized traffic. Each port owns its own address region.
        fork
            port_random(0, 15);
            port_random(1, 15);
            port_random(2, 15);
        join
        repeat (3) @(posedge clk);

        // Reset during the second ACCESS cycle. Port 1 is served first so the
        // pre-reset winner is port 2. After reset, port 1 must win again.
        apply_stimulus(1, 1'b0, 8'h45, 16'h0000);
        release_port(1);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        we = 3'b000; addr1 = 8'h50; addr2 = 8'h90; req = 3'b110;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (gnt != 3'b000) break;
        end
        check_output("pre_reset_grant", 32'(gnt), 32'd4);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_output("midrst_cs", 32'(mem_cs), 32'd0);
        check_output("midrst_gnt", 32'(gnt), 32'd0);
        check_output("midrst_ack", 32'(ack), 32'd0);
        @(negedge clk);
        check_output("midrst_no_ack", 32'(ack), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (gnt != 3'b000 || ack != 3'b000) break;
        end
        check_output("post_reset_grant", 32'(gnt), 32'd2);
        check_output("post_reset_no_ack", 32'(ack), 32'd0);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ack != 3'b000) break;
        end
        check_output("post_reset_ack", 32'(ack), 32'd2);
        check_output("post_reset_rdata", 32'(rdata), 32'(ref_read(8'h50)));
        @(posedge clk);
        #1;
        req = 3'b000;

        // Zero wait states: one select cycle, ack on the next.
        @(posedge clk);
        #1;
        req_z = 3'b001; we_z = 3'b000; addr0_z = 8'h33;
        @(posedge clk);
        @(negedge clk);
        check_output("w0_gnt", 32'(gnt_z), 32'd1);
        check_output("w0_cs", 32'(mem_cs_z), 32'd1);
        check_output("w0_we", 32'(mem_we_z), 32'd0);
        check_output("w0_addr", 32'(mem_addr_z), 32'h33);
        check_output("w0_wdata", 32'(mem_wdata_z), 32'd0);
        check_output("w0_no_ack_yet", 32'(ack_z), 32'd0);
        @(negedge clk);
        check_output("w0_ack", 32'(ack_z), 32'd1);
        check_output("w0_cs_low", 32'(mem_cs_z), 32'd0);
        check_output("w0_rdata", 32'(rdata_z), 32'h0000A5C3);
        @(posedge clk);
        #1;
        req_z = 3'b000;
        @(negedge clk);
        check_output("w0_ack_cleared", 32'(ack_z), 32'd0);
        check_output("w0_gnt_cleared", 32'(gnt_z), 32'd0);
        check_output("w0_idle_cs", 32'(mem_cs_z), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
